// File: rtl/dl_mem_arbiter.sv
// dl_mem_arbiter: one memory port shared round-robin between the CPU
// and a small FIFO of ioctl download bytes; BIOS loads hold the CPU.
module dl_mem_arbiter #(
   parameter int AW         = 17,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          dn_download,
   input  logic [7:0]    dn_index,
   input  logic [AW-1:0] dn_addr,
   input  logic [7:0]    dn_data,
   input  logic          dn_wr,
   output logic          dn_wait,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_wdata,
   output logic          cpu_ack,
   output logic [7:0]    cpu_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   output logic          mem_we,
   output logic [2:0]    mem_sel,
   input  logic [7:0]    mem_rdata,
   output logic          hold_cpu,
   output logic          dn_done,
   output logic          dn_overflow
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DN_WR,
      S_CPU_WR,
      S_CPU_RA,
      S_CPU_RD,
      S_ACK
   } state_t;

   typedef struct packed {
      logic [2:0]    sel;
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } ent_t;

   state_t        state_q, state_d;
   logic          last_q, last_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          dn_wait_q, dn_wait_d;
   logic          cpu_ack_q, cpu_ack_d;
   logic [7:0]    cpu_rdata_q, cpu_rdata_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]    mem_wdata_q, mem_wdata_d;
   logic          mem_we_q, mem_we_d;
   logic [2:0]    mem_sel_q, mem_sel_d;
   logic          hold_q, hold_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          ovf_q, ovf_d;

   ent_t          fifo_mem [FIFO_DEPTH];
   ent_t          head;
   logic [2:0]    sel_dec;
   logic          push, push_ok, pop;
   logic          full, empty;
   logic          dn_elig, cpu_elig;
   logic          grant_dn, grant_cpu;

   always_comb begin
      sel_dec = 3'b000;
      case (dn_index)
         8'd0:    sel_dec = 3'b001;
         8'd3:    sel_dec = 3'b010;
         8'd4:    sel_dec = 3'b100;
         default: sel_dec = 3'b000;
      endcase
   end

   assign full    = (count_q == CW'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   assign head    = fifo_mem[rd_ptr_q];
   assign push    = dn_wr & (|sel_dec);
   assign pop     = (state_q == S_DN_WR);
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign push_ok = push & (~full | pop);

   always_comb begin
      count_d   = count_q + CW'(push_ok) - CW'(pop);
      wr_ptr_d  = wr_ptr_q + PW'(push_ok);
      rd_ptr_d  = rd_ptr_q + PW'(pop);
      dn_wait_d = (count_d >= CW'(FIFO_DEPTH - 1));
      ovf_d     = ovf_q | (push & full & ~pop);
      busy_d    = dn_download | ~empty;
      done_d    = busy_q & ~busy_d;
      hold_d    = (dn_wr & sel_dec[0]) |
                  (hold_q & ~(~dn_download & empty &
                              (state_q == S_IDLE)));
   end

   assign dn_elig   = ~empty;
   // the ack cycle itself is not a request; a held req counts next cycle
   assign cpu_elig  = cpu_req & ~hold_q & ~cpu_ack_q;
   assign grant_dn  = dn_elig & (~cpu_elig | last_q);
   assign grant_cpu = cpu_elig & ~grant_dn;

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = 1'b0;
      mem_sel_d   = 3'b000;
      cpu_ack_d   = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (grant_dn) begin
               state_d     = S_DN_WR;
               last_d      = 1'b0;
               mem_addr_d  = head.addr;
               mem_wdata_d = head.data;
               mem_sel_d   = head.sel;
               mem_we_d    = 1'b1;
            end else if (grant_cpu) begin
               state_d     = cpu_we ? S_CPU_WR : S_CPU_RA;
               last_d      = 1'b1;
               mem_addr_d  = cpu_addr;
               mem_wdata_d = cpu_wdata;
               mem_sel_d   = 3'b001;
               mem_we_d    = cpu_we;
            end
         end
         S_DN_WR:  state_d = S_IDLE;
         S_CPU_WR: state_d = S_ACK;
         S_CPU_RA: state_d = S_CPU_RD;
         S_CPU_RD: begin
            cpu_rdata_d = mem_rdata;
            state_d     = S_ACK;
         end
         S_ACK: begin
            cpu_ack_d = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         last_q      <= 1'b1;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         dn_wait_q   <= 1'b0;
         cpu_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         mem_sel_q   <= 3'b000;
         hold_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         dn_wait_q   <= dn_wait_d;
         cpu_ack_q   <= cpu_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         mem_sel_q   <= mem_sel_d;
         hold_q      <= hold_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ovf_q       <= ovf_d;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push_ok) begin
         fifo_mem[wr_ptr_q] <= '{sel: sel_dec, addr: dn_addr, data: dn_data};
      end
   end

   assign dn_wait     = dn_wait_q;
   assign cpu_ack     = cpu_ack_q;
   assign cpu_rdata   = cpu_rdata_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_we      = mem_we_q;
   assign mem_sel     = mem_sel_q;
   assign hold_cpu    = hold_q;
   assign dn_done     = done_q;
   assign dn_overflow = ovf_q;
endmodule

// File: tb/tb_dl_mem_arbiter.sv
// tb_dl_mem_arbiter: directed scenario tasks for the download/CPU
// memory arbiter, with a small memory model and access log.
module tb_dl_mem_arbiter;
   localparam int AW = 17;

   logic          clk_sys = 1'b0;
   logic          reset_n = 1'b0;
   logic          dn_download = 1'b0;
   logic [7:0]    dn_index = '0;
   logic [AW-1:0] dn_addr = '0;
   logic [7:0]    dn_data = '0;
   logic          dn_wr = 1'b0;
   logic          dn_wait;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [7:0]    cpu_wdata = '0;
   logic          cpu_ack;
   logic [7:0]    cpu_rdata;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          mem_we;
   logic [2:0]    mem_sel;
   logic [7:0]    mem_rdata = '0;
   logic          hold_cpu;
   logic          dn_done;
   logic          dn_overflow;

   typedef struct packed {
      logic          we;
      logic [2:0]    sel;
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } acc_t;

   acc_t        log_q[$];
   int          done_cnt = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [41:0] outs;

   assign outs = {dn_wait, cpu_ack, cpu_rdata, mem_addr, mem_wdata,
                  mem_we, mem_sel, hold_cpu, dn_done, dn_overflow};

   dl_mem_arbiter #(.AW(AW), .FIFO_DEPTH(4)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .dn_download(dn_download), .dn_index(dn_index),
      .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
      .dn_wait(dn_wait), .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
      .cpu_rdata(cpu_rdata), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_sel(mem_sel),
      .mem_rdata(mem_rdata), .hold_cpu(hold_cpu), .dn_done(dn_done),
      .dn_overflow(dn_overflow)
   );

   always #5 clk_sys = ~clk_sys;

   // read data is a fixed function of the address: addr[7:0] + 0x95
   always @(posedge clk_sys) begin
      if (mem_sel != 3'b000 && !mem_we) mem_rdata <= mem_addr[7:0] + 8'h95;
   end

   always @(posedge clk_sys) begin
      if (reset_n && mem_sel != 3'b000)
         log_q.push_back({mem_we, mem_sel, mem_addr, mem_wdata});
      if (dn_done) done_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk_sys);
   endtask

   task automatic idle_inputs();
      dn_download = 0; dn_index = 0; dn_addr = '0; dn_data = 0;
      dn_wr = 0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = 0;
   endtask

   task automatic test_reset();
      int lat;
      reset_n = 0;
      for (int i = 0; i < 4; i++) begin
         dn_download = 1'($urandom); dn_index = 8'($urandom);
         dn_addr = AW'($urandom); dn_data = 8'($urandom);
         dn_wr = 1'($urandom); cpu_req = 1'($urandom);
         cpu_we = 1'($urandom); cpu_addr = AW'($urandom);
         cpu_wdata = 8'($urandom);
         tick();
         n_chk++;
         if (outs !== 42'd0) begin
            n_fail++; $display("FAIL reset_outs: got %h want 0", outs);
         end
      end
      idle_inputs();
      tick();
      reset_n = 1;
      tick(); tick();
      cpu_req = 1; cpu_we = 0; cpu_addr = 17'h00010;
      lat = 0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk_sys); #1;
         if (i == 1) begin
            n_chk++;
            if ({mem_we, mem_sel, mem_addr} !== {1'b0, 3'b001, 17'h00010}) begin
               n_fail++;
               $display("FAIL rd_issue: got we%b sel%b a%h want we0 sel001 a00010",
                        mem_we, mem_sel, mem_addr);
            end
         end
         if (cpu_ack) begin lat = i; break; end
      end
      cpu_req = 0;
      n_chk++;
      if (lat != 4) begin n_fail++; $display("FAIL rd_latency: got %0d want 4", lat); end
      n_chk++;
      if (cpu_rdata !== 8'hA5) begin
         n_fail++; $display("FAIL rd_data: got %h want a5", cpu_rdata);
      end
      @(posedge clk_sys); #1;
      n_chk++;
      if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL ack_pulse: got 1 want 0"); end
      tick();
   endtask

   task automatic test_sprite_live();
      int base, dbase, sent, acks, k, dd, cc, prev;
      bit hold_seen, got;
      base = log_q.size(); dbase = done_cnt;
      sent = 0; acks = 0; hold_seen = 0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 17'h00020;
      dn_download = 1; dn_index = 8'd3;
      for (int c = 0; c < 200 && sent < 8; c++) begin
         if (!dn_wait) begin
            dn_wr = 1; dn_addr = AW'(sent); dn_data = 8'h30 + 8'(sent); sent++;
         end else dn_wr = 0;
         tick();
         hold_seen |= hold_cpu;
         if (cpu_ack) acks++;
      end
      dn_wr = 0;
      for (int c = 0; c < 80; c++) begin
         tick(); hold_seen |= hold_cpu; if (cpu_ack) acks++;
      end
      dn_download = 0;
      got = 0;
      for (int c = 0; c < 12 && !got; c++) begin
         tick(); if (cpu_ack) begin got = 1; acks++; end
      end
      cpu_req = 0;
      repeat (4) tick();
      k = 0; dd = 0; cc = 0; prev = 0;
      for (int i = base; i < log_q.size(); i++) begin
         if (log_q[i].we && log_q[i].sel == 3'b010) begin
            n_chk++;
            if (log_q[i].addr !== AW'(k) || log_q[i].data !== 8'h30 + 8'(k)) begin
               n_fail++;
               $display("FAIL spr_byte%0d: got a%h d%h want a%h d%h", k,
                        log_q[i].addr, log_q[i].data, k, 8'h30 + 8'(k));
            end
            k++;
            if (prev == 1) dd++;
            prev = 1;
         end else begin
            if (prev == 2 && k < 8) cc++;
            prev = 2;
         end
      end
      n_chk++;
      if (k != 8) begin n_fail++; $display("FAIL spr_count: got %0d want 8", k); end
      n_chk++;
      if (dd != 0 || cc != 0) begin
         n_fail++; $display("FAIL spr_alternate: got dn-dn %0d cpu-cpu %0d want 0 0", dd, cc);
      end
      n_chk++;
      if (hold_seen) begin n_fail++; $display("FAIL spr_hold: got 1 want 0"); end
      n_chk++;
      if (done_cnt - dbase != 1) begin
         n_fail++; $display("FAIL spr_done: got %0d pulses want 1", done_cnt - dbase);
      end
      n_chk++;
      if (acks < 4) begin n_fail++; $display("FAIL spr_cpu_acks: got %0d want >=4", acks); end
   endtask

   task automatic test_bios_hold();
      int base, dbase, sent, rd_cnt, k;
      bit ack_seen, wr_seen;
      base = log_q.size(); dbase = done_cnt; sent = 0; ack_seen = 0;
      cpu_req = 1; cpu_we = 1; cpu_addr = 17'h1F000; cpu_wdata = 8'h77;
      tick();
      dn_download = 1; dn_index = 8'd0;
      for (int c = 0; c < 40 && !(sent == 4 && ack_seen); c++) begin
         if (sent < 4 && !dn_wait) begin
            dn_wr = 1; dn_addr = 17'h00100 + AW'(sent);
            dn_data = 8'hB0 + 8'(sent); sent++;
         end else dn_wr = 0;
         tick();
         if (cpu_ack) begin ack_seen = 1; cpu_we = 0; cpu_addr = 17'h00040; end
      end
      dn_wr = 0;
      n_chk++;
      if (!ack_seen) begin n_fail++; $display("FAIL bios_cpu_wr_ack: got 0 want 1"); end
      n_chk++;
      if (hold_cpu !== 1'b1) begin n_fail++; $display("FAIL bios_hold_set: got %b want 1", hold_cpu); end
      repeat (15) tick();
      n_chk++;
      if (hold_cpu !== 1'b1) begin n_fail++; $display("FAIL bios_hold_kept: got %b want 1", hold_cpu); end
      k = 0; wr_seen = 0; rd_cnt = 0;
      for (int i = base; i < log_q.size(); i++) begin
         if (log_q[i].sel == 3'b001 && !log_q[i].we) rd_cnt++;
         else if (log_q[i].we && log_q[i].addr == 17'h1F000)
            wr_seen = (log_q[i].data == 8'h77) && (log_q[i].sel == 3'b001);
         else if (log_q[i].we && log_q[i].sel == 3'b001) begin
            n_chk++;
            if (log_q[i].addr !== 17'h00100 + AW'(k) || log_q[i].data !== 8'hB0 + 8'(k)) begin
               n_fail++;
               $display("FAIL bios_byte%0d: got a%h d%h", k, log_q[i].addr, log_q[i].data);
            end
            k++;
         end
      end
      n_chk++;
      if (!wr_seen) begin n_fail++; $display("FAIL bios_cpu_wr_mem: got 0 want 1"); end
      n_chk++;
      if (k != 4) begin n_fail++; $display("FAIL bios_count: got %0d want 4", k); end
      n_chk++;
      if (rd_cnt != 0) begin n_fail++; $display("FAIL bios_no_grant: got %0d want 0", rd_cnt); end
      dn_download = 0;
      tick();
      n_chk++;
      if (hold_cpu !== 1'b0) begin n_fail++; $display("FAIL bios_hold_clr: got %b want 0", hold_cpu); end
      ack_seen = 0;
      for (int c = 0; c < 12 && !ack_seen; c++) begin
         tick(); if (cpu_ack) ack_seen = 1;
      end
      cpu_req = 0;
      n_chk++;
      if (!ack_seen) begin n_fail++; $display("FAIL bios_cpu_resume: got 0 want 1"); end
      repeat (3) tick();
      n_chk++;
      if (done_cnt - dbase != 1) begin
         n_fail++; $display("FAIL bios_done: got %0d want 1", done_cnt - dbase);
      end
   endtask

   task automatic test_overflow();
      int base, wait_at, k;
      bit got;
      logic [7:0] exp_d [5];
      exp_d = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC5};
      base = log_q.size(); wait_at = 0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 17'h00050;
      dn_download = 1; dn_index = 8'd4;
      for (int i = 0; i < 6; i++) begin
         dn_wr = 1; dn_addr = 17'h00200 + AW'(i); dn_data = 8'hC0 + 8'(i);
         tick();
         if (wait_at == 0 && dn_wait) wait_at = i + 1;
      end
      dn_wr = 0;
      n_chk++;
      if (wait_at != 3) begin n_fail++; $display("FAIL ovf_wait_at: got %0d want 3", wait_at); end
      n_chk++;
      if (dn_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", dn_overflow); end
      dn_download = 0;
      repeat (60) tick();
      got = 0;
      for (int c = 0; c < 12 && !got; c++) begin tick(); got = cpu_ack; end
      cpu_req = 0;
      repeat (3) tick();
      k = 0;
      for (int i = base; i < log_q.size(); i++) begin
         if (log_q[i].we && log_q[i].sel == 3'b100) begin
            if (k < 5) begin
               n_chk++;
               if (log_q[i].data !== exp_d[k]) begin
                  n_fail++;
                  $display("FAIL ovf_byte%0d: got %h want %h", k, log_q[i].data, exp_d[k]);
               end
            end
            k++;
         end
      end
      n_chk++;
      if (k != 5) begin n_fail++; $display("FAIL ovf_count: got %0d want 5", k); end
      n_chk++;
      if ({dn_overflow, dn_wait} !== 2'b10) begin
         n_fail++; $display("FAIL ovf_sticky: got ovf%b wait%b want ovf1 wait0", dn_overflow, dn_wait);
      end
   endtask

   task automatic test_ignored_index();
      int base, dbase;
      base = log_q.size(); dbase = done_cnt;
      dn_download = 1; dn_index = 8'd2;
      for (int i = 0; i < 3; i++) begin
         dn_wr = 1; dn_addr = 17'h00300 + AW'(i); dn_data = 8'hE0 + 8'(i);
         tick();
      end
      dn_wr = 0;
      tick(); tick();
      n_chk++;
      if (dn_wait !== 1'b0) begin n_fail++; $display("FAIL ign_wait: got %b want 0", dn_wait); end
      dn_download = 0;
      repeat (4) tick();
      n_chk++;
      if (log_q.size() != base) begin
         n_fail++; $display("FAIL ign_no_write: got %0d accesses want 0", log_q.size() - base);
      end
      n_chk++;
      if (done_cnt - dbase != 1) begin
         n_fail++; $display("FAIL ign_done: got %0d want 1", done_cnt - dbase);
      end
   endtask

   task automatic test_reset_mid_read();
      int base, lat;
      bit ack_seen;
      cpu_req = 1; cpu_we = 0; cpu_addr = 17'h00060;
      tick();
      dn_download = 1; dn_index = 8'd3; dn_wr = 1;
      dn_addr = 17'h00400; dn_data = 8'hD0;
      tick();
      reset_n = 0; dn_wr = 0;
      #1;
      n_chk++;
      if (outs !== 42'd0) begin n_fail++; $display("FAIL mid_rst_outs: got %h want 0", outs); end
      tick();
      n_chk++;
      if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ack: got 1 want 0"); end
      cpu_req = 0; dn_download = 0;
      reset_n = 1;
      base = log_q.size(); ack_seen = 0;
      repeat (6) begin tick(); if (cpu_ack) ack_seen = 1; end
      n_chk++;
      if (ack_seen) begin n_fail++; $display("FAIL mid_rst_late_ack: got 1 want 0"); end
      n_chk++;
      if (log_q.size() != base || dn_wait !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_rst_flush: got %0d accesses wait%b want 0 0",
                  log_q.size() - base, dn_wait);
      end
      cpu_req = 1; cpu_we = 0; cpu_addr = 17'h00033;
      lat = 0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk_sys); #1;
         if (cpu_ack) begin lat = i; break; end
      end
      cpu_req = 0;
      n_chk++;
      if (lat != 4 || cpu_rdata !== 8'hC8) begin
         n_fail++;
         $display("FAIL mid_rst_idle_rd: got lat%0d d%h want lat4 dc8", lat, cpu_rdata);
      end
      tick();
   endtask

   initial begin
      idle_inputs();
      tick();
      test_reset();
      test_sprite_live();
      test_bios_hold();
      test_overflow();
      test_ignored_index();
      test_reset_mid_read();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
